// File: rtl/ghost_mover_if.sv
// Connection bundle between the ghost direction-decision logic (master)
// and the ghost position executor (slave).
interface ghost_mover_if;
  logic        enable;
  logic        move_tick;
  logic        respawn;
  logic [3:0]  move_direction;
  logic [10:0] ghost_pos_x;
  logic [9:0]  ghost_pos_y;
  logic [3:0]  prev_direction;
  logic        at_tile;
  logic        stalled;
  logic        step_done;

  modport master (
    output enable, move_tick, respawn, move_direction,
    input  ghost_pos_x, ghost_pos_y, prev_direction, at_tile, stalled, step_done
  );

  modport slave (
    input  enable, move_tick, respawn, move_direction,
    output ghost_pos_x, ghost_pos_y, prev_direction, at_tile, stalled, step_done
  );
endinterface

// File: rtl/ghost_mover.sv
// Ghost position executor: steps the ghost one STEP per movement tick and
// only commits a new heading when it sits exactly on a tile boundary.
module ghost_mover #(
  parameter int         TILE      = 16,
  parameter int         STEP      = 1,
  parameter int         START_X   = 320,
  parameter int         START_Y   = 240,
  parameter logic [3:0] START_DIR = 4'b1000,
  parameter int         MAX_X     = 639,
  parameter int         MAX_Y     = 479
) (
  input  logic          clk,
  input  logic          rst,
  ghost_mover_if.slave  bus
);

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [1:0] {ALIGNED, MOVING, STALL} state_t;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
  } pos_t;

  localparam pos_t START_POS = '{x: 11'(START_X), y: 10'(START_Y)};

  state_t     state_q, nxt_state;
  pos_t       pos_q, nxt_pos;
  logic [3:0] dir_q, nxt_dir;
  logic       stalled_q, nxt_stalled;
  logic       step_done_q;
  logic       moved;
  logic       dir_valid;

  function automatic logic is_aligned(input pos_t p);
    return ((p.x & 11'(TILE - 1)) == '0) && ((p.y & 10'(TILE - 1)) == '0);
  endfunction

  // Both axes wrap through the tunnel: the playfield is treated as a torus.
  function automatic pos_t step_pos(input pos_t p, input logic [3:0] dir);
    pos_t r;
    r = p;
    case (dir)
      DIR_RIGHT: r.x = (int'(p.x) + STEP > MAX_X) ? 11'(int'(p.x) + STEP - (MAX_X + 1))
                                                  : 11'(int'(p.x) + STEP);
      DIR_LEFT:  r.x = (int'(p.x) < STEP) ? 11'(int'(p.x) + MAX_X + 1 - STEP)
                                          : 11'(int'(p.x) - STEP);
      DIR_DOWN:  r.y = (int'(p.y) + STEP > MAX_Y) ? 10'(int'(p.y) + STEP - (MAX_Y + 1))
                                                  : 10'(int'(p.y) + STEP);
      DIR_UP:    r.y = (int'(p.y) < STEP) ? 10'(int'(p.y) + MAX_Y + 1 - STEP)
                                          : 10'(int'(p.y) - STEP);
      default:   r = p;
    endcase
    return r;
  endfunction

  assign dir_valid = (bus.move_direction != '0) &&
                     ((bus.move_direction & (bus.move_direction - 4'd1)) == '0);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    nxt_state   = state_q;
    nxt_pos     = pos_q;
    nxt_dir     = dir_q;
    nxt_stalled = stalled_q;
    moved       = 1'b0;
    case (state_q)
      ALIGNED, STALL: begin
        if (dir_valid) begin
          nxt_dir     = bus.move_direction;
          nxt_pos     = step_pos(pos_q, bus.move_direction);
          nxt_stalled = 1'b0;
          moved       = 1'b1;
          nxt_state   = is_aligned(nxt_pos) ? ALIGNED : MOVING;
        end else begin
          nxt_stalled = 1'b1;
          nxt_state   = STALL;
        end
      end
      MOVING: begin
        // Between tiles the request is ignored and the heading is kept.
        nxt_pos   = step_pos(pos_q, dir_q);
        moved     = 1'b1;
        nxt_state = is_aligned(nxt_pos) ? ALIGNED : MOVING;
      end
      default: nxt_state = ALIGNED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    step_done_q <= 1'b0;
    if (rst || bus.respawn) begin
      state_q   <= ALIGNED;
      pos_q     <= START_POS;
      dir_q     <= START_DIR;
      stalled_q <= 1'b0;
    end else if (bus.enable && bus.move_tick) begin
      state_q     <= nxt_state;
      pos_q       <= nxt_pos;
      dir_q       <= nxt_dir;
      stalled_q   <= nxt_stalled;
      step_done_q <= moved;
    end
  end

  assign bus.ghost_pos_x    = pos_q.x;
  assign bus.ghost_pos_y    = pos_q.y;
  assign bus.prev_direction = dir_q;
  assign bus.at_tile        = is_aligned(pos_q);
  assign bus.stalled        = stalled_q;
  assign bus.step_done      = step_done_q;

endmodule

// File: tb/tb_ghost_mover.sv
// Directed bench for ghost_mover: a default instance plus one whose start x
// is 0 so the left/right tunnel wrap can be reached quickly.
module tb_ghost_mover;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ghost_mover_if bus ();
  ghost_mover_if bus_w ();

  ghost_mover dut (.clk(clk), .rst(rst), .bus(bus));
  ghost_mover #(.START_X(0)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pos(input string tag, input int x, input int y, input int dir);
    check({tag, " x"},   32'(bus.ghost_pos_x), x);
    check({tag, " y"},   32'(bus.ghost_pos_y), y);
    check({tag, " dir"}, 32'(bus.prev_direction), dir);
  endtask

  task automatic do_respawn();
    bus.respawn = 1'b1;
    cycle();
    bus.respawn = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.enable = 1'b0;   bus.move_tick = 1'b0;   bus.respawn = 1'b0;
    bus.move_direction = 4'b0000;
    bus_w.enable = 1'b0; bus_w.move_tick = 1'b0; bus_w.respawn = 1'b0;
    bus_w.move_direction = 4'b0000;
    cycle();
    rst = 1'b0;

    // Reset state
    check_pos("reset", 320, 240, 4'b1000);
    check("reset at_tile", 32'(bus.at_tile), 1);
    check("reset stalled", 32'(bus.stalled), 0);
    check("reset step_done", 32'(bus.step_done), 0);

    // Straight run left across one tile, one-cycle tick pulses
    bus.enable = 1'b1;
    bus.move_direction = 4'b1000;
    for (int i = 1; i <= 16; i++) begin
      bus.move_tick = 1'b1;
      cycle();
      bus.move_tick = 1'b0;
      check($sformatf("run x %0d", i), 32'(bus.ghost_pos_x), 320 - i);
      check($sformatf("run at_tile %0d", i), 32'(bus.at_tile), (i == 16) ? 1 : 0);
      check($sformatf("run step_done %0d", i), 32'(bus.step_done), 1);
      cycle();
      check($sformatf("run step_done low %0d", i), 32'(bus.step_done), 0);
    end
    check_pos("run end", 304, 240, 4'b1000);

    // Mid-tile requests are ignored until the next tile boundary
    do_respawn();
    bus.move_direction = 4'b1000;
    bus.move_tick = 1'b1;
    cycle();
    check("mid first x", 32'(bus.ghost_pos_x), 319);
    bus.move_direction = 4'b0010;
    repeat (15) cycle();
    check_pos("mid ignore", 304, 240, 4'b1000);
    check("mid at_tile", 32'(bus.at_tile), 1);
    cycle();
    bus.move_tick = 1'b0;
    check_pos("mid turn up", 304, 239, 4'b0010);

    // Stall on missing direction, then recover
    do_respawn();
    bus.move_direction = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      bus.move_tick = 1'b1;
      cycle();
      bus.move_tick = 1'b0;
      check($sformatf("stall flag %0d", i), 32'(bus.stalled), 1);
      check($sformatf("stall x %0d", i), 32'(bus.ghost_pos_x), 320);
      check($sformatf("stall step_done %0d", i), 32'(bus.step_done), 0);
      cycle();
    end
    bus.move_direction = 4'b0110;
    bus.move_tick = 1'b1;
    cycle();
    bus.move_tick = 1'b0;
    check("stall non-onehot", 32'(bus.stalled), 1);
    check("stall non-onehot y", 32'(bus.ghost_pos_y), 240);
    bus.move_direction = 4'b0001;
    bus.move_tick = 1'b1;
    cycle();
    bus.move_tick = 1'b0;
    check_pos("stall exit", 321, 240, 4'b0001);
    check("stall exit flag", 32'(bus.stalled), 0);
    check("stall exit step_done", 32'(bus.step_done), 1);

    // rst and respawn together with a tick while mid-move
    rst = 1'b1;
    bus.respawn = 1'b1;
    bus.move_tick = 1'b1;
    cycle();
    rst = 1'b0;
    bus.respawn = 1'b0;
    bus.move_tick = 1'b0;
    check_pos("prio rst", 320, 240, 4'b1000);
    check("prio rst step_done", 32'(bus.step_done), 0);
    check("prio rst stalled", 32'(bus.stalled), 0);

    // Respawn beats a tick at x=310
    bus.move_direction = 4'b1000;
    bus.move_tick = 1'b1;
    repeat (10) cycle();
    check("prio pre x", 32'(bus.ghost_pos_x), 310);
    bus.respawn = 1'b1;
    cycle();
    bus.respawn = 1'b0;
    bus.move_tick = 1'b0;
    check_pos("prio respawn", 320, 240, 4'b1000);
    check("prio respawn step_done", 32'(bus.step_done), 0);

    // Freeze: enable low ignores held ticks, then resume mid-move
    bus.move_tick = 1'b1;
    cycle();
    bus.move_tick = 1'b0;
    check("freeze pre x", 32'(bus.ghost_pos_x), 319);
    bus.enable = 1'b0;
    bus.move_direction = 4'b0010;
    bus.move_tick = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      check($sformatf("freeze x %0d", i), 32'(bus.ghost_pos_x), 319);
      check($sformatf("freeze step_done %0d", i), 32'(bus.step_done), 0);
    end
    check_pos("freeze hold", 319, 240, 4'b1000);
    bus.enable = 1'b1;
    cycle();
    bus.move_tick = 1'b0;
    check_pos("freeze resume", 318, 240, 4'b1000);
    check("freeze resume step_done", 32'(bus.step_done), 1);

    // Tunnel wrap on the instance starting at x=0
    bus_w.respawn = 1'b1;
    cycle();
    bus_w.respawn = 1'b0;
    check("wrap start x", 32'(bus_w.ghost_pos_x), 0);
    bus_w.enable = 1'b1;
    bus_w.move_direction = 4'b1000;
    bus_w.move_tick = 1'b1;
    cycle();
    check("wrap left x", 32'(bus_w.ghost_pos_x), 639);
    check("wrap left at_tile", 32'(bus_w.at_tile), 0);
    check("wrap left y", 32'(bus_w.ghost_pos_y), 240);
    repeat (15) cycle();
    check("wrap left 16 x", 32'(bus_w.ghost_pos_x), 624);
    check("wrap left 16 at_tile", 32'(bus_w.at_tile), 1);
    bus_w.move_direction = 4'b0001;
    repeat (15) cycle();
    check("wrap right 15 x", 32'(bus_w.ghost_pos_x), 639);
    cycle();
    bus_w.move_tick = 1'b0;
    check("wrap right x", 32'(bus_w.ghost_pos_x), 0);
    check("wrap right at_tile", 32'(bus_w.at_tile), 1);
    check("wrap right dir", 32'(bus_w.prev_direction), 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ghost_mover.md
Name: ghost_mover

Overview:
- Sequential position executor for one ghost.
- Consumes the one-hot move_direction produced by the ghost direction-decision logic and advances the ghost's pixel position on each movement tick.
- Feeds its registered position and last-taken direction back to that decision logic.
- New directions are committed only on tile-grid boundaries; between boundaries the ghost keeps its current heading.

Parameters:
- TILE, 16: tile edge in pixels; power of two.
- STEP, 1: pixels moved per tick; must divide TILE.
- START_X, 320: x loaded at reset/respawn; multiple of TILE.
- START_Y, 240: y loaded at reset/respawn; multiple of TILE.
- START_DIR, 4'b1000: direction loaded at reset/respawn (LEFT).
- MAX_X, 639: largest x; MAX_X+1 is a multiple of TILE.
- MAX_Y, 479: largest y; MAX_Y+1 is a multiple of TILE.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  low = freeze; ticks ignored, state held.
- move_tick  in  1  one-cycle pulse; one movement step per pulse.
- respawn  in  1  synchronous reload of start position and direction.
- move_direction  in  4  one-hot request from decision logic (RIGHT=0001, UP=0010, DOWN=0100, LEFT=1000).
- ghost_pos_x  out  11  registered x.
- ghost_pos_y  out  10  registered y.
- prev_direction  out  4  registered direction currently being travelled.
- at_tile  out  1  high when x and y are both multiples of TILE (combinational from registers).
- stalled  out  1  high while the ghost is waiting at a tile with no valid direction.
- step_done  out  1  one-cycle pulse, registered, on every cycle in which the position changed.

Behaviour:
- Reset (rst=1 at posedge):
  - ghost_pos_x=START_X, ghost_pos_y=START_Y, prev_direction=START_DIR.
  - stalled=0, step_done=0, state=ALIGNED.
- Priority: rst > respawn > (enable & move_tick). Respawn applies the same values as reset, mid-move or stalled.
- FSM states: ALIGNED, MOVING, STALL.
- ALIGNED (at_tile=1), on tick:
  - If move_direction is exactly one-hot: prev_direction<=move_direction, position steps STEP in that direction, state<=MOVING.
  - If the stepped position lands on a tile (possible when STEP=TILE), stay in ALIGNED.
  - Zero or non-one-hot move_direction: no move, prev_direction unchanged, stalled<=1, state<=STALL.
- STALL, on tick:
  - Re-evaluate move_direction exactly as in ALIGNED.
  - On a valid direction: stalled<=0 and step.
- MOVING, on tick:
  - Step STEP along prev_direction; move_direction is ignored.
  - If the new position is tile-aligned, state<=ALIGNED.
- Step arithmetic:
  - RIGHT: x+STEP; LEFT: x-STEP; DOWN: y+STEP; UP: y-STEP.
  - Computed modulo MAX_X+1 / MAX_Y+1 (tunnel wrap). LEFT from x=0 gives MAX_X+1-STEP; RIGHT from MAX_X+1-STEP gives 0.
  - The orthogonal coordinate is unchanged.
- Latency:
  - Position and prev_direction update on the posedge where move_tick=1.
  - step_done is high the following cycle, for one cycle.
- enable=0: ticks are ignored, no outputs change, step_done=0. Resuming continues from the held state.
- move_tick held high for N cycles counts as N ticks.
- No direction filtering here: reversal and wall legality belong to the decision logic. This block only checks one-hotness.

Test Plan:
- Reset: rst 1 cycle -> x=320, y=240, prev_direction=1000, at_tile=1, stalled=0, step_done=0.
- Straight run: move_direction=1000, 16 ticks -> x=304, y=240, at_tile=1 after tick 16 only, 16 step_done pulses each one cycle after its tick.
- Mid-tile ignore: after 1 LEFT tick (x=319), drive move_direction=0010 for 15 ticks -> x=304, y=240, prev_direction=1000. Next tick with 0010 -> y=239, prev_direction=0010.
- Stall: at (320,240) drive move_direction=0000 for 3 ticks, then 0001 -> stalled=1 for 3 ticks, position fixed, no step_done. Fourth tick gives x=321, stalled=0.
- Wrap: respawn with START_X overridden to 0, LEFT, 1 tick -> x=639. 15 more ticks -> x=624, at_tile=1.
- Priority: rst and respawn asserted together with move_tick mid-move -> reset values. respawn with tick at x=310 -> x=320, y=240, prev_direction=1000, no step_done. enable=0 with 5 ticks -> no change.
